exe_controller: RTL and testbench

EXE_CONTROLLER -- requirements
Module: exe_controller

---
 rtl/exe_controller.sv | 139 +++++++++++++
 tb/tb_exe_controller.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_controller.sv
// EXE-stage pipeline controller: freeze/flush/hazard stall, NZCV status register, memory-wait timeout.
// Optional macro FORWARDING_EN adds the fwdSel1/fwdSel2 ports and limits hazards to load-use.
module exe_controller (
  input  logic       clk,
  input  logic       rstN,
  input  logic       idValid,
  input  logic [3:0] idSrc1,
  input  logic [3:0] idSrc2,
  input  logic       idUsesSrc2,
  input  logic       exeValid,
  input  logic       exeWbEn,
  input  logic [3:0] exeDest,
  input  logic [3:0] exeSrc1,
  input  logic [3:0] exeSrc2,
  input  logic       exeMemRead,
  input  logic       exeBranch,
  input  logic       exeStatusUpdate,
  input  logic       aluN,
  input  logic       aluZ,
  input  logic       aluC,
  input  logic       aluV,
  input  logic       memValid,
  input  logic       memWbEn,
  input  logic [3:0] memDest,
  input  logic       memReq,
  input  logic       memReady,
  input  logic       wbValid,
  input  logic       wbWbEn,
  input  logic [3:0] wbDest,
  output logic [3:0] statusNZCV,
  output logic       freeze,
  output logic       hazardStall,
  output logic       flush,
  output logic       memTimeout
`ifdef FORWARDING_EN
  ,
  output logic [1:0] fwdSel1,
  output logic [1:0] fwdSel2
`endif
);

  localparam logic [3:0] PC_REG = 4'd15;

  typedef enum logic {ST_RUN, ST_WAIT} state_t;

  state_t     r_state;
  state_t     w_stateNext;
  logic [7:0] r_waitCount;
  logic       r_memTimeout;
  logic [3:0] r_status;

  logic w_freeze;
  logic w_flush;
  logic w_src1Hit;
  logic w_src2Hit;
  logic w_src2Live;

  assign w_freeze   = memValid & memReq & ~memReady;
  assign w_flush    = exeValid & exeBranch & ~w_freeze;
  assign w_src2Live = idUsesSrc2 & (idSrc2 != PC_REG);

`ifdef FORWARDING_EN
  logic w_exeLoad;

  // Everything except a load in EXE is covered by forwarding.
  assign w_exeLoad = exeValid & exeWbEn & exeMemRead;
  assign w_src1Hit = (idSrc1 != PC_REG) & w_exeLoad & (idSrc1 == exeDest);
  assign w_src2Hit = w_src2Live & w_exeLoad & (idSrc2 == exeDest);

  logic w_memFwd;
  logic w_wbFwd;

  assign w_memFwd = memValid & memWbEn;
  assign w_wbFwd  = wbValid & wbWbEn;

  always_comb begin
    fwdSel1 = 2'b00;
    fwdSel2 = 2'b00;
    if (exeSrc1 != PC_REG) begin
      if (w_memFwd && exeSrc1 == memDest)     fwdSel1 = 2'b01;
      else if (w_wbFwd && exeSrc1 == wbDest)  fwdSel1 = 2'b10;
    end
    if (exeSrc2 != PC_REG) begin
      if (w_memFwd && exeSrc2 == memDest)     fwdSel2 = 2'b01;
      else if (w_wbFwd && exeSrc2 == wbDest)  fwdSel2 = 2'b10;
    end
  end
`else
  logic w_exeWr;
  logic w_memWr;
  logic w_unused;

  assign w_exeWr   = exeValid & exeWbEn;
  assign w_memWr   = memValid & memWbEn;
  assign w_src1Hit = (idSrc1 != PC_REG) &
                     ((w_exeWr & (idSrc1 == exeDest)) | (w_memWr & (idSrc1 == memDest)));
  assign w_src2Hit = w_src2Live &
                     ((w_exeWr & (idSrc2 == exeDest)) | (w_memWr & (idSrc2 == memDest)));
  // Source/WB fields only matter to the forwarding muxes.
  assign w_unused  = ^{exeSrc1, exeSrc2, wbValid, wbWbEn, wbDest};
`endif

  assign freeze      = w_freeze;
  assign flush       = w_flush;
  assign hazardStall = idValid & ~w_flush & ~w_freeze & (w_src1Hit | w_src2Hit);
  assign statusNZCV  = r_status;
  assign memTimeout  = r_memTimeout;

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_RUN:  if (w_freeze)  w_stateNext = ST_WAIT;
      ST_WAIT: if (!w_freeze) w_stateNext = ST_RUN;
      default: w_stateNext = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      r_state      <= ST_RUN;
      r_waitCount  <= '0;
      r_memTimeout <= 1'b0;
      r_status     <= '0;
    end else begin
      r_state <= w_stateNext;
      if (exeValid && exeStatusUpdate && !w_freeze)
        r_status <= {aluN, aluZ, aluC, aluV};
      if (r_state == ST_RUN)
        r_waitCount <= '0;
      else if (w_freeze && r_waitCount != 8'hFF)
        r_waitCount <= r_waitCount + 8'd1;
      if (w_stateNext == ST_RUN)
        r_memTimeout <= 1'b0;
      else if (r_state == ST_WAIT && r_waitCount == 8'hFF)
        r_memTimeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_exe_controller.sv
// Self-checking bench for exe_controller: table-driven combinational vectors, flag and timeout sequences.
module tb_exe_controller;

  logic       clk = 1'b0;
  logic       rstN;
  logic       idValid, idUsesSrc2;
  logic [3:0] idSrc1, idSrc2;
  logic       exeValid, exeWbEn, exeMemRead, exeBranch, exeStatusUpdate;
  logic [3:0] exeDest, exeSrc1, exeSrc2;
  logic       aluN, aluZ, aluC, aluV;
  logic       memValid, memWbEn, memReq, memReady;
  logic [3:0] memDest;
  logic       wbValid, wbWbEn;
  logic [3:0] wbDest;
  logic [3:0] statusNZCV;
  logic       freeze, hazardStall, flush, memTimeout;
`ifdef FORWARDING_EN
  logic [1:0] fwdSel1, fwdSel2;
`endif

  always #5 clk = ~clk;

  exe_controller dut (
    .clk(clk), .rstN(rstN),
    .idValid(idValid), .idSrc1(idSrc1), .idSrc2(idSrc2), .idUsesSrc2(idUsesSrc2),
    .exeValid(exeValid), .exeWbEn(exeWbEn), .exeDest(exeDest), .exeSrc1(exeSrc1),
    .exeSrc2(exeSrc2), .exeMemRead(exeMemRead), .exeBranch(exeBranch),
    .exeStatusUpdate(exeStatusUpdate), .aluN(aluN), .aluZ(aluZ), .aluC(aluC), .aluV(aluV),
    .memValid(memValid), .memWbEn(memWbEn), .memDest(memDest), .memReq(memReq),
    .memReady(memReady), .wbValid(wbValid), .wbWbEn(wbWbEn), .wbDest(wbDest),
    .statusNZCV(statusNZCV), .freeze(freeze), .hazardStall(hazardStall), .flush(flush),
    .memTimeout(memTimeout)
`ifdef FORWARDING_EN
    , .fwdSel1(fwdSel1), .fwdSel2(fwdSel2)
`endif
  );

  typedef struct {
    string       name;
    logic [15:0] exp;
  } sb_t;

  typedef struct {
    string      name;
    logic       idV;
    logic [3:0] s1, s2;
    logic       u2, exV, exWb;
    logic [3:0] exD;
    logic       exMr, exBr, mV, mWb;
    logic [3:0] mD;
    logic       mReq, mRdy;
    logic       eFz, eFl, eHz, eHzF;
  } vec_t;

  sb_t  exp_q[$];
  vec_t vecs[15];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic expect_val(input string name, input logic [15:0] v);
    sb_t e;
    e.name = name;
    e.exp  = v;
    exp_q.push_back(e);
  endtask

  task automatic check_val(input logic [15:0] act);
    sb_t e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard_empty actual=%0h", act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e.exp) begin
        n_err++;
        $display("FAIL %s actual=%0h required=%0h", e.name, act, e.exp);
      end
    end
  endtask

  task automatic idle();
    idValid = 0; idSrc1 = 0; idSrc2 = 0; idUsesSrc2 = 0;
    exeValid = 0; exeWbEn = 0; exeDest = 0; exeSrc1 = 0; exeSrc2 = 0;
    exeMemRead = 0; exeBranch = 0; exeStatusUpdate = 0;
    {aluN, aluZ, aluC, aluV} = 4'b0000;
    memValid = 0; memWbEn = 0; memDest = 0; memReq = 0; memReady = 0;
    wbValid = 0; wbWbEn = 0; wbDest = 0;
  endtask

  // Counts edges until memTimeout is seen high; 999 if the budget runs out.
  task automatic measure_timeout(output int n);
    n = 999;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk); #1;
      if (memTimeout === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int   n;
    logic hzExp;

    vecs[0]  = '{"loaduse",        1, 3, 0, 0, 1,1, 3,1,0, 0,0, 0,0,0, 0,0,1,1};
    vecs[1]  = '{"alu_raw_exe",    1, 3, 0, 0, 1,1, 3,0,0, 0,0, 0,0,0, 0,0,1,0};
    vecs[2]  = '{"mem_raw_src2",   1, 1, 5, 1, 0,0, 0,0,0, 1,1, 5,0,0, 0,0,1,0};
    vecs[3]  = '{"src2_unused",    1, 1, 5, 0, 0,0, 0,0,0, 1,1, 5,0,0, 0,0,0,0};
    vecs[4]  = '{"r15_load",       1,15, 0, 0, 1,1,15,1,0, 0,0, 0,0,0, 0,0,0,0};
    vecs[5]  = '{"r15_mem_src2",   1, 0,15, 1, 0,0, 0,0,0, 1,1,15,0,0, 0,0,0,0};
    vecs[6]  = '{"branch_loaduse", 1, 3, 0, 0, 1,1, 3,1,1, 0,0, 0,0,0, 0,1,0,0};
    vecs[7]  = '{"freeze_br_lu",   1, 3, 0, 0, 1,1, 3,1,1, 1,0, 0,1,0, 1,0,0,0};
    vecs[8]  = '{"mem_ready",      1, 3, 0, 0, 1,1, 3,1,0, 1,0, 0,1,1, 0,0,1,1};
    vecs[9]  = '{"freeze_hazard",  1, 3, 0, 0, 1,1, 3,1,0, 1,0, 0,1,0, 1,0,0,0};
    vecs[10] = '{"id_invalid",     0, 3, 0, 0, 1,1, 3,1,0, 0,0, 0,0,0, 0,0,0,0};
    vecs[11] = '{"exe_nowb",       1, 3, 0, 0, 1,0, 3,1,0, 0,0, 0,0,0, 0,0,0,0};
    vecs[12] = '{"exe_inv_branch", 1, 3, 0, 0, 0,1, 3,1,1, 0,0, 0,0,0, 0,0,0,0};
    vecs[13] = '{"mem_wb_off",     1, 7, 0, 0, 0,0, 0,0,0, 1,0, 7,0,0, 0,0,0,0};
    vecs[14] = '{"no_match",       1, 2, 4, 1, 1,1, 3,1,0, 1,1, 5,0,0, 0,0,0,0};

    idle();
    rstN = 0;
    repeat (2) @(posedge clk);
    #1;
    expect_val("reset_status", 16'h0);  check_val({12'h0, statusNZCV});
    expect_val("reset_timeout", 16'h0); check_val({15'h0, memTimeout});
    @(negedge clk);
    rstN = 1;

    foreach (vecs[i]) begin
      @(negedge clk);
      idle();
      idValid = vecs[i].idV; idSrc1 = vecs[i].s1; idSrc2 = vecs[i].s2; idUsesSrc2 = vecs[i].u2;
      exeValid = vecs[i].exV; exeWbEn = vecs[i].exWb; exeDest = vecs[i].exD;
      exeMemRead = vecs[i].exMr; exeBranch = vecs[i].exBr;
      memValid = vecs[i].mV; memWbEn = vecs[i].mWb; memDest = vecs[i].mD;
      memReq = vecs[i].mReq; memReady = vecs[i].mRdy;
`ifdef FORWARDING_EN
      hzExp = vecs[i].eHzF;
`else
      hzExp = vecs[i].eHz;
`endif
      expect_val({vecs[i].name, "_freeze"}, {15'h0, vecs[i].eFz});
      expect_val({vecs[i].name, "_flush"},  {15'h0, vecs[i].eFl});
      expect_val({vecs[i].name, "_stall"},  {15'h0, hzExp});
      #2;
      check_val({15'h0, freeze});
      check_val({15'h0, flush});
      check_val({15'h0, hazardStall});
    end

`ifdef FORWARDING_EN
    @(negedge clk);
    idle();
    exeSrc1 = 3; exeSrc2 = 4; memValid = 1; memWbEn = 1; memDest = 3;
    wbValid = 1; wbWbEn = 1; wbDest = 3;
    expect_val("fwd1_mem_over_wb", 16'h1); expect_val("fwd2_none", 16'h0);
    #2; check_val({14'h0, fwdSel1}); check_val({14'h0, fwdSel2});
    @(negedge clk);
    memWbEn = 0; wbDest = 4; exeSrc1 = 4;
    expect_val("fwd1_wb", 16'h2); expect_val("fwd2_wb", 16'h2);
    #2; check_val({14'h0, fwdSel1}); check_val({14'h0, fwdSel2});
    @(negedge clk);
    idle();
    exeSrc1 = 15; memValid = 1; memWbEn = 1; memDest = 15;
    expect_val("fwd1_r15", 16'h0);
    #2; check_val({14'h0, fwdSel1});
`endif

    // Flag register: load, freeze-blocked, held, then reloaded.
    @(negedge clk);
    idle();
    exeValid = 1; exeStatusUpdate = 1; {aluN, aluZ, aluC, aluV} = 4'b1001;
    expect_val("flags_before_edge", 16'h0);
    #1; check_val({12'h0, statusNZCV});
    expect_val("flags_load", 16'h9);
    @(posedge clk); #1; check_val({12'h0, statusNZCV});
    @(negedge clk);
    {aluN, aluZ, aluC, aluV} = 4'b0110; memValid = 1; memReq = 1; memReady = 0;
    expect_val("flags_freeze_hold", 16'h9);
    @(posedge clk); #1; check_val({12'h0, statusNZCV});
    @(negedge clk);
    memValid = 0; memReq = 0; exeStatusUpdate = 0;
    expect_val("flags_no_s_hold", 16'h9);
    @(posedge clk); #1; check_val({12'h0, statusNZCV});
    @(negedge clk);
    exeStatusUpdate = 1; exeValid = 0;
    expect_val("flags_invalid_hold", 16'h9);
    @(posedge clk); #1; check_val({12'h0, statusNZCV});
    @(negedge clk);
    exeValid = 1;
    expect_val("flags_reload", 16'h6);
    @(posedge clk); #1; check_val({12'h0, statusNZCV});
    @(negedge clk);
    idle();
    @(posedge clk);

    // Memory wait timeout.
    @(negedge clk);
    memValid = 1; memReq = 1; memReady = 0;
    expect_val("timeout_edges", 16'd257);
    measure_timeout(n);
    check_val(n[15:0]);
    repeat (43) @(posedge clk);
    #1;
    expect_val("timeout_held", 16'h1); check_val({15'h0, memTimeout});
    @(negedge clk);
    memReady = 1;
    expect_val("ready_unfreeze", 16'h0);
    #1; check_val({15'h0, freeze});
    expect_val("timeout_clear", 16'h0);
    @(posedge clk); #1; check_val({15'h0, memTimeout});
    @(negedge clk);
    memReady = 0;
    expect_val("timeout_edges_again", 16'd257);
    measure_timeout(n);
    check_val(n[15:0]);

    // Reset in WAIT with timeout raised and flags set.
    @(negedge clk);
    rstN = 0;
    expect_val("freeze_in_reset", 16'h1);
    #1; check_val({15'h0, freeze});
    @(posedge clk); #1;
    expect_val("rst_timeout", 16'h0); check_val({15'h0, memTimeout});
    expect_val("rst_status", 16'h0);  check_val({12'h0, statusNZCV});
    @(negedge clk);
    rstN = 1;
    expect_val("timeout_after_reset", 16'd257);
    measure_timeout(n);
    check_val(n[15:0]);

    @(negedge clk);
    idle();
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
